// File: rtl/dcache_axi_ram_slave_pkg.sv
// Shared encodings for the data-cache AXI3 RAM responder: burst types,
// response codes, controller states and the per-beat address step.
package dcache_axi_ram_slave_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_BURST,
        ST_WR_DATA,
        ST_WR_RESP
    } state_t;

    // Address of the following beat. FIXED stays put; WRAP and the reserved
    // encoding are stepped like INCR, which is all the cache master issues.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        if (burst == BURST_FIXED) begin
            return addr;
        end
        return addr + (32'd1 << size);
    endfunction

endpackage

// File: rtl/dcache_axi_ram_slave_mem.sv
// Single-port synchronous RAM, 2^AW x 32 with per-byte write enables and a
// registered read port (read-before-write). Contents are never reset.
module dcache_axi_ram_slave_mem #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] ram [0:(1 << AW) - 1];
    logic [31:0] rdata_reg;

    // Byte-lane writes and registered read of the addressed word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                ram[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        rdata_reg <= ram[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dcache_axi_ram_slave.sv
// AXI3 responder for the data cache master. One transaction at a time,
// single-beat or INCR/FIXED bursts up to 16 beats, with a programmable read
// latency so the master's stall paths can be exercised.
module dcache_axi_ram_slave
    import dcache_axi_ram_slave_pkg::*;
#(
    parameter int MEM_AW   = 12,
    parameter int READ_LAT = 1
) (
    input  logic        aclk,
    input  logic        areset,
    // read address
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    // read data
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    // write address
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    // write data
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    // Last value of the wait counter before the first data beat is shown.
    localparam logic [3:0] LAT_LAST = 4'((READ_LAT > 1) ? (READ_LAT - 2) : 0);

    state_t      state_reg, state_next;
    logic [3:0]  id_reg;
    logic [31:0] addr_reg;
    logic [3:0]  len_reg;
    logic [2:0]  size_reg;
    logic [1:0]  burst_reg;
    logic [3:0]  beat_reg;
    logic [3:0]  lat_cnt_reg;
    logic        err_reg;

    logic        ar_hs, aw_hs, r_hs, w_hs;
    logic        last_beat;
    logic [31:0] addr_adv;
    logic [MEM_AW-1:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_q;

    // Lock, cache, protection and write id carry no meaning for this memory.
    logic unused_inputs;
    assign unused_inputs = ^{wid, arlock, arcache, arprot, awlock, awcache, awprot};

    assign ar_hs     = arvalid & arready;
    assign aw_hs     = awvalid & awready;
    assign r_hs      = rvalid & rready;
    assign w_hs      = wvalid & wready;
    assign last_beat = (beat_reg == len_reg);
    assign addr_adv  = next_addr(addr_reg, size_reg, burst_reg);

    // State register; reset abandons any transaction in flight immediately.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs. Reads win a simultaneous AR/AW.
    always_comb begin
        state_next = state_reg;
        arready    = 1'b0;
        awready    = 1'b0;
        rvalid     = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                arready = 1'b1;
                awready = ~arvalid;
                if (arvalid) begin
                    state_next = (READ_LAT <= 1) ? ST_RD_BURST : ST_RD_WAIT;
                end else if (awvalid) begin
                    state_next = ST_WR_DATA;
                end
            end
            ST_RD_WAIT: begin
                if (lat_cnt_reg == LAT_LAST) begin
                    state_next = ST_RD_BURST;
                end
            end
            ST_RD_BURST: begin
                rvalid = 1'b1;
                if (rready && last_beat) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                wready = 1'b1;
                if (wvalid && last_beat) begin
                    state_next = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Transaction context: captured on address handshakes, stepped per beat.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            id_reg      <= '0;
            addr_reg    <= '0;
            len_reg     <= '0;
            size_reg    <= '0;
            burst_reg   <= '0;
            beat_reg    <= '0;
            lat_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            if (ar_hs) begin
                id_reg      <= arid;
                addr_reg    <= araddr;
                len_reg     <= arlen;
                size_reg    <= arsize;
                burst_reg   <= arburst;
                beat_reg    <= '0;
                lat_cnt_reg <= '0;
            end else if (aw_hs) begin
                id_reg    <= awid;
                addr_reg  <= awaddr;
                len_reg   <= awlen;
                size_reg  <= awsize;
                burst_reg <= awburst;
                beat_reg  <= '0;
                err_reg   <= 1'b0;
            end
            if (state_reg == ST_RD_WAIT) begin
                lat_cnt_reg <= lat_cnt_reg + 4'd1;
            end
            if (r_hs || w_hs) begin
                addr_reg <= addr_adv;
                beat_reg <= beat_reg + 4'd1;
            end
            // The burst length, not wlast, ends the data phase; a misplaced
            // or missing wlast only poisons the response.
            if (w_hs) begin
                if (last_beat) begin
                    err_reg <= err_reg | ~wlast;
                end else if (wlast) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    // RAM address: prefetch the AR address while idle, the next word on a
    // read handshake, otherwise keep re-reading the current word so stalled
    // beats hold their data.
    always_comb begin
        mem_addr = addr_reg[MEM_AW+1:2];
        if (state_reg == ST_IDLE) begin
            mem_addr = araddr[MEM_AW+1:2];
        end else if (r_hs) begin
            mem_addr = addr_adv[MEM_AW+1:2];
        end
    end

    assign mem_we = w_hs ? wstrb : 4'b0000;

    dcache_axi_ram_slave_mem #(
        .AW(MEM_AW)
    ) u_mem (
        .clk  (aclk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(wdata),
        .rdata(mem_q)
    );

    assign rdata = rvalid ? mem_q : 32'd0;
    assign rlast = rvalid & last_beat;
    assign rresp = RESP_OKAY;
    assign rid   = id_reg;
    assign bid   = id_reg;
    assign bresp = (bvalid && err_reg) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_dcache_axi_ram_slave.sv
// Bench for dcache_axi_ram_slave: two instances (read latency 1 and 4) driven
// by directed and random AXI transactions, checked against a word-array
// memory model held in the bench.
module tb_dcache_axi_ram_slave;

    localparam int MEM_AW = 12;
    localparam int NW     = 1 << MEM_AW;

    logic aclk = 1'b0;
    int   cyc  = 0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    logic        areset  [2];
    logic [3:0]  arid    [2];
    logic [31:0] araddr  [2];
    logic [3:0]  arlen   [2];
    logic [2:0]  arsize  [2];
    logic [1:0]  arburst [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [3:0]  rid     [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rlast   [2];
    logic        rvalid  [2];
    logic        rready  [2];
    logic [3:0]  awid    [2];
    logic [31:0] awaddr  [2];
    logic [3:0]  awlen   [2];
    logic [2:0]  awsize  [2];
    logic [1:0]  awburst [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [3:0]  wid     [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic        wlast   [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic [3:0]  bid     [2];
    logic [1:0]  bresp   [2];
    logic        bvalid  [2];
    logic        bready  [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        dcache_axi_ram_slave #(
            .MEM_AW  (MEM_AW),
            .READ_LAT(gi == 0 ? 1 : 4)
        ) dut (
            .aclk   (aclk),
            .areset (areset[gi]),
            .arid   (arid[gi]),
            .araddr (araddr[gi]),
            .arlen  (arlen[gi]),
            .arsize (arsize[gi]),
            .arburst(arburst[gi]),
            .arlock (2'b01),
            .arcache(4'b0011),
            .arprot (3'b010),
            .arvalid(arvalid[gi]),
            .arready(arready[gi]),
            .rid    (rid[gi]),
            .rdata  (rdata[gi]),
            .rresp  (rresp[gi]),
            .rlast  (rlast[gi]),
            .rvalid (rvalid[gi]),
            .rready (rready[gi]),
            .awid   (awid[gi]),
            .awaddr (awaddr[gi]),
            .awlen  (awlen[gi]),
            .awsize (awsize[gi]),
            .awburst(awburst[gi]),
            .awlock (2'b10),
            .awcache(4'b1100),
            .awprot (3'b101),
            .awvalid(awvalid[gi]),
            .awready(awready[gi]),
            .wid    (wid[gi]),
            .wdata  (wdata[gi]),
            .wstrb  (wstrb[gi]),
            .wlast  (wlast[gi]),
            .wvalid (wvalid[gi]),
            .wready (wready[gi]),
            .bid    (bid[gi]),
            .bresp  (bresp[gi]),
            .bvalid (bvalid[gi]),
            .bready (bready[gi])
        );
    end

    // Reference memory: one word array per instance.
    logic [31:0] mdl [2][NW];
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'(NW - 1));
    endfunction

    function automatic logic [31:0] step(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + (32'd1 << size);
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_aw(input int d, input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, output int t_hs);
        bit done = 0;
        awid[d] = id; awaddr[d] = addr; awlen[d] = len; awsize[d] = size; awburst[d] = burst;
        awvalid[d] = 1'b1;
        t_hs = -1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge aclk);
            done = awready[d];
            tick();
        end
        awvalid[d] = 1'b0;
        if (done) t_hs = cyc;
        else check_eq("aw_timeout", 0, 1);
    endtask

    task automatic do_ar(input int d, input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, output int t_hs);
        bit done = 0;
        arid[d] = id; araddr[d] = addr; arlen[d] = len; arsize[d] = size; arburst[d] = burst;
        arvalid[d] = 1'b1;
        t_hs = -1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge aclk);
            done = arready[d];
            tick();
        end
        arvalid[d] = 1'b0;
        if (done) t_hs = cyc;
        else check_eq("ar_timeout", 0, 1);
    endtask

    // Data phase of a write plus the response; wlast_beat<0 means never.
    task automatic do_w(input int d, input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                        input logic [1:0] burst, input int wlast_beat, input bit gaps, input logic [3:0] id);
        logic [31:0] a = addr;
        int          n;
        for (int b = 0; b <= int'(len); b++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                wvalid[d] = 1'b0;
                @(negedge aclk);
                check_eq("wready_in_gap", 32'(wready[d]), 1);
                tick();
            end
            wvalid[d] = 1'b1; wdata[d] = wbuf[b]; wstrb[d] = sbuf[b];
            wlast[d] = (b == wlast_beat); wid[d] = 4'($urandom);
            @(negedge aclk);
            check_eq("wready", 32'(wready[d]), 1);
            for (int k = 0; k < 4; k++) begin
                if (sbuf[b][k]) mdl[d][widx(a)][k*8 +: 8] = wbuf[b][k*8 +: 8];
            end
            a = step(a, size, burst);
            tick();
        end
        wvalid[d] = 1'b0; wlast[d] = 1'b0;
        @(negedge aclk);
        check_eq("bvalid", 32'(bvalid[d]), 1);
        check_eq("bresp", 32'(bresp[d]), (wlast_beat == int'(len)) ? 0 : 2);
        check_eq("bid", 32'(bid[d]), 32'(id));
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            tick();
            @(negedge aclk);
            check_eq("bvalid_hold", 32'(bvalid[d]), 1);
        end
        tick();
        bready[d] = 1'b1;
        tick();
        bready[d] = 1'b0;
        @(negedge aclk);
        check_eq("bvalid_clear", 32'(bvalid[d]), 0);
        check_eq("arready_after_b", 32'(arready[d]), 1);
        tick();
    endtask

    // Read data phase. Ends #1 after the last R handshake edge (t_end), or
    // after a reset pulse fired on beat rst_beat.
    task automatic do_r(input int d, input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                        input logic [1:0] burst, input logic [3:0] id, input int t_hs, input int mode,
                        input int rst_beat, output int t_end);
        logic [31:0] a = addr;
        logic [31:0] held = '0;
        int          b = 0;
        bit          first = 1;
        bit          stalled = 0;
        t_end = -1;
        for (int k = 0; k < 400 && b <= int'(len); k++) begin
            case (mode)
                0:       rready[d] = 1'b1;
                1:       rready[d] = (k % 2 == 0);
                default: rready[d] = 1'($urandom_range(0, 1));
            endcase
            @(negedge aclk);
            if (rvalid[d]) begin
                if (first) begin
                    check_eq("r_first_latency", 32'(cyc - t_hs + 1), 32'(lat_of(d)));
                    first = 0;
                end
                if (stalled) check_eq("r_hold_data", rdata[d], held);
                if (b == rst_beat) begin
                    #1 areset[d] = 1'b1;
                    #1;
                    check_eq("rst_rvalid", 32'(rvalid[d]), 0);
                    check_eq("rst_rlast", 32'(rlast[d]), 0);
                    check_eq("rst_arready", 32'(arready[d]), 1);
                    tick();
                    areset[d] = 1'b0;
                    rready[d] = 1'b0;
                    return;
                end
                if (rready[d]) begin
                    check_eq("rdata", rdata[d], mdl[d][widx(a)]);
                    check_eq("rlast", 32'(rlast[d]), 32'(b == int'(len)));
                    check_eq("rid", 32'(rid[d]), 32'(id));
                    check_eq("rresp", 32'(rresp[d]), 0);
                    a = step(a, size, burst);
                    b++;
                    stalled = 0;
                    t_end = cyc + 1;
                end else begin
                    stalled = 1;
                    held = rdata[d];
                end
            end else if (!first) begin
                check_eq("rvalid_dropped", 0, 1);
            end
            tick();
        end
        rready[d] = 1'b0;
        if (b <= int'(len)) begin
            check_eq("r_timeout", 32'(b), 32'(int'(len) + 1));
            t_end = -1;
        end
    endtask

    task automatic axi_write(input int d, input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int wlast_beat, input bit gaps);
        int          t_hs;
        logic [3:0]  id = 4'($urandom);
        $display("WR dut=%0d addr=%h len=%0d size=%0d burst=%0d wlast_beat=%0d", d, addr, len, size, burst, wlast_beat);
        do_aw(d, addr, len, size, burst, id, t_hs);
        if (t_hs >= 0) do_w(d, addr, len, size, burst, wlast_beat, gaps, id);
    endtask

    task automatic axi_read(input int d, input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int mode);
        int          t_hs, t_end;
        logic [3:0]  id = 4'($urandom);
        $display("RD dut=%0d addr=%h len=%0d size=%0d burst=%0d rready_mode=%0d", d, addr, len, size, burst, mode);
        do_ar(d, addr, len, size, burst, id, t_hs);
        if (t_hs < 0) return;
        do_r(d, addr, len, size, burst, id, t_hs, mode, -1, t_end);
        if (t_end >= 0) begin
            if (mode == 0) check_eq("r_total_cycles", 32'(t_end - t_hs), 32'(lat_of(d) + int'(len)));
            @(negedge aclk);
            check_eq("arready_after_r", 32'(arready[d]), 1);
            tick();
        end
    endtask

    task automatic fill_bufs(input logic [31:0] base, input logic [31:0] inc, input bit rnd);
        for (int i = 0; i < 16; i++) begin
            wbuf[i] = rnd ? $urandom : base + inc * 32'(i);
            sbuf[i] = 4'hF;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          t_hs, t_end;
        int          d;
        logic [3:0]  len, id_r, id_w;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] addr;

        for (int i = 0; i < 2; i++) begin
            areset[i] = 1'b1;
            arid[i] = '0; araddr[i] = '0; arlen[i] = '0; arsize[i] = '0; arburst[i] = '0; arvalid[i] = 1'b0;
            rready[i] = 1'b0;
            awid[i] = '0; awaddr[i] = '0; awlen[i] = '0; awsize[i] = '0; awburst[i] = '0; awvalid[i] = 1'b0;
            wid[i] = '0; wdata[i] = '0; wstrb[i] = '0; wlast[i] = 1'b0; wvalid[i] = 1'b0;
            bready[i] = 1'b0;
        end
        repeat (2) @(posedge aclk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_arready", 32'(arready[i]), 1);
            check_eq("rst_awready", 32'(awready[i]), 1);
            check_eq("rst_rvalid", 32'(rvalid[i]), 0);
            check_eq("rst_rlast", 32'(rlast[i]), 0);
            check_eq("rst_rdata", rdata[i], 0);
            check_eq("rst_rresp", 32'(rresp[i]), 0);
            check_eq("rst_rid", 32'(rid[i]), 0);
            check_eq("rst_wready", 32'(wready[i]), 0);
            check_eq("rst_bvalid", 32'(bvalid[i]), 0);
            check_eq("rst_bresp", 32'(bresp[i]), 0);
            check_eq("rst_bid", 32'(bid[i]), 0);
        end
        tick();
        for (int i = 0; i < 2; i++) areset[i] = 1'b0;
        tick();

        // Single read of a preloaded word.
        fill_bufs(32'hDEADBEEF, 0, 0);
        axi_write(0, 32'h400, 0, 2, 2'b01, 0, 0);
        axi_read(0, 32'h400, 0, 2, 2'b01, 0);

        // 16-beat burst write then read back.
        fill_bufs(0, 32'h11111111, 0);
        axi_write(0, 32'h1000, 15, 2, 2'b01, 15, 0);
        axi_read(0, 32'h1000, 15, 2, 2'b01, 0);

        // Byte strobes merge into the existing word.
        fill_bufs(32'hFFFFFFFF, 0, 0);
        axi_write(0, 32'h80, 0, 2, 2'b01, 0, 0);
        wbuf[0] = 32'h12345678; sbuf[0] = 4'b0101;
        axi_write(0, 32'h80, 0, 2, 2'b01, 0, 0);
        axi_read(0, 32'h80, 0, 2, 2'b01, 0);
        check_eq("strobe_merge_ref", mdl[0][32], 32'hFF34FF78);

        // Write with wvalid gaps.
        fill_bufs(0, 0, 1);
        axi_write(0, 32'h1200, 7, 2, 2'b01, 7, 1);
        axi_read(0, 32'h1200, 7, 2, 2'b01, 2);

        // Wrap modulo RAM size, upper address bits ignored.
        fill_bufs(0, 0, 1);
        axi_write(0, 32'h8000_3FF8, 3, 2, 2'b01, 3, 0);
        axi_read(0, 32'h0000_3FF8, 3, 2, 2'b01, 0);

        // Simultaneous AR and AW: read first, write right after rlast.
        id_r = 4'($urandom); id_w = 4'($urandom);
        arid[0] = id_r; araddr[0] = 32'h1000; arlen[0] = 3; arsize[0] = 2; arburst[0] = 2'b01;
        awid[0] = id_w; awaddr[0] = 32'h1100; awlen[0] = 3; awsize[0] = 2; awburst[0] = 2'b01;
        arvalid[0] = 1'b1; awvalid[0] = 1'b1;
        $display("RD+WR dut=0 simultaneous ar=%h aw=%h", 32'h1000, 32'h1100);
        @(negedge aclk);
        check_eq("arb_arready", 32'(arready[0]), 1);
        check_eq("arb_awready", 32'(awready[0]), 0);
        tick();
        t_hs = cyc;
        arvalid[0] = 1'b0;
        do_r(0, 32'h1000, 3, 2, 2'b01, id_r, t_hs, 0, -1, t_end);
        @(negedge aclk);
        check_eq("aw_after_rlast", 32'(awready[0]), 1);
        tick();
        awvalid[0] = 1'b0;
        fill_bufs(0, 0, 1);
        do_w(0, 32'h1100, 3, 2, 2'b01, 3, 0, id_w);
        axi_read(0, 32'h1100, 3, 2, 2'b01, 0);

        // Early wlast and missing wlast both end by length with SLVERR.
        fill_bufs(0, 0, 1);
        axi_write(0, 32'h1300, 3, 2, 2'b01, 1, 0);
        axi_read(0, 32'h1300, 3, 2, 2'b01, 0);
        fill_bufs(0, 0, 1);
        axi_write(1, 32'h1400, 2, 2, 2'b01, -1, 0);
        axi_read(1, 32'h1400, 2, 2, 2'b01, 0);

        // Latency 4 with rready toggling.
        fill_bufs(0, 0, 1);
        axi_write(1, 32'h3000, 7, 2, 2'b01, 7, 0);
        axi_read(1, 32'h3000, 7, 2, 2'b01, 1);

        // Initialise a random-test window in both instances.
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 16; r++) begin
                fill_bufs(0, 0, 1);
                axi_write(i, 32'h2000 + 32'(r * 64), 15, 2, 2'b01, 15, 0);
            end
        end

        // Reset during beat 5 of a 16-beat read, then a clean read.
        $display("RD dut=1 addr=00002000 len=15 reset on beat 5");
        do_ar(1, 32'h2000, 15, 2, 2'b01, 4'h9, t_hs);
        do_r(1, 32'h2000, 15, 2, 2'b01, 4'h9, t_hs, 0, 5, t_end);
        @(negedge aclk);
        check_eq("post_rst_arready", 32'(arready[1]), 1);
        check_eq("post_rst_rvalid", 32'(rvalid[1]), 0);
        tick();
        axi_read(1, 32'h2040, 15, 2, 2'b01, 2);

        // Random write/read-back pairs inside the initialised window.
        for (int it = 0; it < 24; it++) begin
            d     = $urandom_range(0, 1);
            len   = 4'($urandom);
            size  = 3'($urandom_range(0, 2));
            burst = 2'($urandom_range(0, 2));
            addr  = 32'h2000 + 32'($urandom_range(0, 1024 - 68));
            for (int i = 0; i < 16; i++) begin
                wbuf[i] = $urandom;
                sbuf[i] = 4'($urandom);
            end
            axi_write(d, addr, len, size, burst, int'(len), 1'($urandom_range(0, 1)));
            axi_read(d, addr, len, size, burst, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_axi_ram_slave.md
# dcache_axi_ram_slave

AXI3 responder serving the data cache's bus master: accepts single-beat and INCR bursts (up to 16 beats, 32-bit data), backed by a byte-writable synchronous RAM. Used as the memory model in block- and SoC-level simulation, and as a BRAM-backed scratch memory on FPGA. Handles one transaction at a time, with programmable read latency so master stall paths can be exercised.

## Interface
- MEM_AW, 12: log2 of RAM depth in 32-bit words (16 KiB default).
- READ_LAT, 1: cycles from AR handshake to first rvalid; legal range 1..15.
- aclk  in  1  clock; all logic rising-edge.
- areset  in  1  reset; one clock; asynchronous, active-high.
- arid/araddr/arlen/arsize/arburst  in  4/32/4/3/2  read address channel.
- arlock/arcache/arprot  in  2/4/3  ignored.
- arvalid  in  1, arready  out  1.
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1, rready  in  1.
- awid/awaddr/awlen/awsize/awburst  in  4/32/4/3/2; awlock/awcache/awprot  in  ignored.
- awvalid  in  1, awready  out  1.
- wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1, wready  out  1.
- bid/bresp/bvalid  out  4/2/1, bready  in  1.

## Operation
- States: IDLE, RD_WAIT, RD_BURST, WR_DATA, WR_RESP.
- arready = (state==IDLE). awready = (state==IDLE) & !arvalid. Read wins a simultaneous AR/AW; AW stays pending.
- AR handshake latches id, address, len, size and burst; beat counter = 0; goes to RD_WAIT. The latency counter counts READ_LAT-1 cycles, then the block goes to RD_BURST (READ_LAT=1 goes straight to RD_BURST).
- RD_BURST: rvalid=1, rdata=mem[addr[MEM_AW+1:2]], rresp=00, rid=latched id, rlast=(beat==len).
- On each rvalid&rready, the address advances: +(1<<size) for INCR (01); unchanged for FIXED (00); WRAP (10) is treated as INCR.
- After the last beat handshakes, the block returns to IDLE.
- AW handshake latches id, address, len, size and burst, then goes to WR_DATA with wready=1.
- Each wvalid&wready writes the wstrb-enabled bytes of wdata at the word address, then advances the address as for reads.
- The beat with beat==len ends the data phase whatever wlast says. bresp is 10 (SLVERR) if wlast was seen before beat==len or absent on it; otherwise 00.
- WR_RESP: bvalid=1, bid=latched id; on bready the block goes to IDLE.
- Addresses wrap modulo RAM size; there is no decode error. Narrow reads return the full aligned word.
- wid and arid/awid value are not checked.
- Reset values: arready=1, awready=1, rvalid=0, rlast=0, rdata=0, rresp=00, rid=0, wready=0, bvalid=0, bresp=00, bid=0, state=IDLE.
- RAM contents are not reset.
- Reset mid-burst abandons the transaction. Bytes already written stay written.

## Timing
- AR handshake at cycle T: first rvalid at T+READ_LAT.
- Subsequent beats are back-to-back while rready=1.
- rdata/rlast/rid must hold stable while rvalid&!rready. The next word is fetched only on handshake, so synchronous RAM read is one cycle ahead of use.
- AW handshake at T: wready=1 from T+1. Written data is visible to a read starting one cycle after the write.
- Last W handshake at T: bvalid from T+1, held until bready.
- Return to IDLE: arready/awready high the cycle after the final R or B handshake. A new AR may be accepted that cycle.
- 16-beat read with rready held high: READ_LAT+16 cycles from AR to the cycle after rlast.

## Structure
- Shared package: AXI burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY=00, SLVERR=10), state encoding.
- Sub-module dcache_axi_ram_slave_mem: single-port synchronous RAM, 2^MEM_AW x 32, 4-bit byte write enable, registered read. Inferable as BRAM.

## Test plan
- Single read: preload word 0x100 = 0xDEADBEEF; AR addr 0x400, len 0, size 2 -> one beat 0xDEADBEEF, rlast=1, rresp=00, at T+1.
- Burst write then read:
  - AW 0x1000, len 15; W beats 0..15 = i*0x11111111, wlast on beat 15 -> bresp=00, bvalid at T_last+1.
  - AR same address, len 15 -> identical 16 words in order, rlast only on beat 15.
- Byte strobe: mem[0x20]=0xFFFFFFFF; write wdata=0x12345678, wstrb=0101 -> read returns 0xFF34FF78.
- Backpressure and latency:
  - READ_LAT=4, rready toggled 1/0 each cycle over an 8-beat read -> first rvalid at T+4, data held during stalls, 8 distinct beats.
  - wvalid gaps during a write -> no beats lost.
- Arbitration and errors:
  - arvalid and awvalid together -> read served first, write accepted after rlast.
  - len=3 write with wlast on beat 1 -> 4 beats consumed, bresp=10.
- Reset mid-burst: assert areset during beat 5 of a 16-beat read -> rvalid=0 the same cycle; arready=1 after release; a new read completes correctly.
